cb_cycle_sequencer: RTL

Per-instruction timing sequencer and CB-prefix tracker for the CPU control unit, placed directly upstream of the CB microcode decoder. Generates the one-hot T-state step and one-hot M-cycle count consumed by all microcode decoders. Latches fetched opcode bytes from the data bus. On detecting the 0xCB prefix, it runs a dedicated prefix-fetch M-cycle, loads the second byte into Z, and holds CB mode active until the CB decoder releases it.

---
 rtl/cb_cycle_sequencer_pkg.sv | 29 ++
 rtl/cb_cycle_sequencer_if.sv | 42 ++++
 rtl/cb_cycle_sequencer_t_state_ring.sv | 42 ++++
 rtl/cb_cycle_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/cb_cycle_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// cb_cycle_sequencer_pkg
//   Shared control-unit definitions for the cycle sequencer and its decoders.
//   - seq_state_t   : sequencer ownership state (RUN / CB_FETCH / CB)
//   - CB_PREFIX     : opcode byte that enters CB mode
//   - STEP_RESET    : one-hot T-state value after reset
//   - COUNT_RESET   : one-hot M-cycle count value after reset / after a fetch
//   - count_advance : one-hot M-cycle count shift with wrap from bit 7 to bit 0
// ----------------------------------------------------------------------------
package cb_cycle_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,  // main decoder owns the M-cycle
        ST_CB_FETCH = 2'd1,  // sequencer fetches the CB second byte
        ST_CB       = 2'd2   // CB decoder owns the M-cycle
    } seq_state_t;

    localparam logic [7:0] CB_PREFIX    = 8'hCB;
    localparam logic [7:0] RESET_OPCODE = 8'h00;
    localparam logic [3:0] STEP_RESET   = 4'b0001;
    localparam logic [7:0] COUNT_RESET  = 8'b0000_0001;

    // Rotating (rather than shifting) makes the wrap from 1000_0000 back to
    // 0000_0001 fall out naturally; the caller flags the wrap separately.
    function automatic logic [7:0] count_advance(input logic [7:0] count);
        return {count[6:0], count[7]};
    endfunction

endpackage : cb_cycle_sequencer_pkg

// File: rtl/cb_cycle_sequencer_if.sv
// ----------------------------------------------------------------------------
// cb_cycle_sequencer_if
//   Bundles the sequencer's control inputs and timing/opcode outputs.
//   Handshake: there is no valid/ready pair; the inputs i_IR_Fetch,
//   i_Disable_CB and i_Data_Bus are qualified solely by an enabled clock edge
//   while o_Cycle_Step == 4'b1000 (the M-cycle boundary) and are don't-care
//   at every other edge.
//   Modports:
//     master : drives i_* (control unit / bench), observes o_*
//     slave  : the sequencer itself
//   o_State is a debug view of the sequencer FSM state.
// ----------------------------------------------------------------------------
interface cb_cycle_sequencer_if;
    import cb_cycle_sequencer_pkg::*;

    logic        i_Clk_Enable;
    logic [7:0]  i_Data_Bus;
    logic        i_IR_Fetch;
    logic        i_Disable_CB;

    logic [3:0]  o_Cycle_Step;
    logic [7:0]  o_Cycle_Count;
    logic [7:0]  o_IR;
    logic [7:0]  o_Z;
    logic        o_CB_Active;
    logic        o_Prefix_Fetch;
    logic        o_Cycle_Overflow;
    seq_state_t  o_State;

    modport master (
        output i_Clk_Enable, i_Data_Bus, i_IR_Fetch, i_Disable_CB,
        input  o_Cycle_Step, o_Cycle_Count, o_IR, o_Z, o_CB_Active,
               o_Prefix_Fetch, o_Cycle_Overflow, o_State
    );

    modport slave (
        input  i_Clk_Enable, i_Data_Bus, i_IR_Fetch, i_Disable_CB,
        output o_Cycle_Step, o_Cycle_Count, o_IR, o_Z, o_CB_Active,
               o_Prefix_Fetch, o_Cycle_Overflow, o_State
    );

endinterface : cb_cycle_sequencer_if

// File: rtl/cb_cycle_sequencer_t_state_ring.sv
// ----------------------------------------------------------------------------
// t_state_ring
//   4-bit one-hot T-state ring counter.
//   Ports:
//     i_Clk      : clock
//     i_Reset    : asynchronous active-high reset (step -> 4'b0001)
//     i_Enable   : advance qualifier; 0 holds the step
//     o_Step     : one-hot T-state 0001 -> 0010 -> 0100 -> 1000 -> 0001
//     o_Boundary : high when the next rising edge ends the M-cycle
// ----------------------------------------------------------------------------
module t_state_ring
    import cb_cycle_sequencer_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Enable,
    output logic [3:0] o_Step,
    output logic       o_Boundary
);

    logic [3:0] step_q;
    logic [3:0] step_d;

    always_comb begin
        step_d = step_q;
        if (i_Enable) begin
            step_d = {step_q[2:0], step_q[3]};
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            step_q <= STEP_RESET;
        end else begin
            step_q <= step_d;
        end
    end

    assign o_Step     = step_q;
    assign o_Boundary = step_q[3] & i_Enable;

endmodule : t_state_ring

// File: rtl/cb_cycle_sequencer.sv
// ----------------------------------------------------------------------------
// cb_cycle_sequencer
//   Per-instruction timing sequencer and CB-prefix tracker. Produces the
//   one-hot T-state step and one-hot M-cycle count, latches opcode bytes
//   from the data bus, and runs a dedicated prefix-fetch M-cycle when the
//   CB prefix is seen, holding CB mode until the CB decoder releases it.
//   Parameters:
//     CB_PREFIX    : opcode byte that enters CB mode
//     RESET_OPCODE : reset value of o_IR and o_Z
//   Ports:
//     i_Clk   : clock, all state changes on the rising edge
//     i_Reset : asynchronous active-high reset
//     bus     : cb_cycle_sequencer_if.slave (enable, data bus, fetch/release
//               requests in; step, count, IR, Z, CB/prefix status, overflow
//               flag and debug state out)
// ----------------------------------------------------------------------------
module cb_cycle_sequencer
    import cb_cycle_sequencer_pkg::*;
#(
    parameter logic [7:0] CB_PREFIX    = cb_cycle_sequencer_pkg::CB_PREFIX,
    parameter logic [7:0] RESET_OPCODE = cb_cycle_sequencer_pkg::RESET_OPCODE
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    cb_cycle_sequencer_if.slave  bus
);

    seq_state_t  state_q,     state_d;
    logic [7:0]  count_q,     count_d;
    logic [7:0]  ir_q,        ir_d;
    logic [7:0]  z_q,         z_d;
    logic        overflow_q,  overflow_d;
    logic        cb_active_q, cb_active_d;
    logic        prefix_q,    prefix_d;

    logic [3:0]  step;
    logic        boundary;
    logic        take_fetch;
    logic        is_prefix;

    t_state_ring u_t_state_ring (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_Enable   (bus.i_Clk_Enable),
        .o_Step     (step),
        .o_Boundary (boundary)
    );

    // In CB mode the CB decoder's release and the main decoder's fetch both
    // mean "the next opcode is on the bus"; in RUN only the fetch counts.
    always_comb begin
        take_fetch = 1'b0;
        case (state_q)
            ST_RUN:  take_fetch = bus.i_IR_Fetch;
            ST_CB:   take_fetch = bus.i_IR_Fetch | bus.i_Disable_CB;
            default: take_fetch = 1'b0;
        endcase
    end

    assign is_prefix = (bus.i_Data_Bus == CB_PREFIX);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ir_d       = ir_q;
        z_d        = z_q;
        overflow_d = overflow_q;

        if (boundary) begin
            case (state_q)
                ST_CB_FETCH: begin
                    z_d     = bus.i_Data_Bus;
                    count_d = COUNT_RESET;
                    state_d = ST_CB;
                end
                ST_RUN, ST_CB: begin
                    if (take_fetch) begin
                        ir_d    = bus.i_Data_Bus;
                        count_d = COUNT_RESET;
                        state_d = is_prefix ? ST_CB_FETCH : ST_RUN;
                    end else begin
                        count_d = count_advance(count_q);
                        if (count_q[7]) begin
                            overflow_d = 1'b1;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: restart the instruction cleanly.
                    count_d = COUNT_RESET;
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Status bits are registered decodes of the next state so they switch
    // glitch-free, exactly when step wraps back to 0001.
    always_comb begin
        cb_active_d = (state_d == ST_CB);
        prefix_d    = (state_d == ST_CB_FETCH);
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= ST_RUN;
            count_q     <= COUNT_RESET;
            ir_q        <= RESET_OPCODE;
            z_q         <= RESET_OPCODE;
            overflow_q  <= 1'b0;
            cb_active_q <= 1'b0;
            prefix_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ir_q        <= ir_d;
            z_q         <= z_d;
            overflow_q  <= overflow_d;
            cb_active_q <= cb_active_d;
            prefix_q    <= prefix_d;
        end
    end

    assign bus.o_Cycle_Step     = step;
    assign bus.o_Cycle_Count    = count_q;
    assign bus.o_IR             = ir_q;
    assign bus.o_Z              = z_q;
    assign bus.o_CB_Active      = cb_active_q;
    assign bus.o_Prefix_Fetch   = prefix_q;
    assign bus.o_Cycle_Overflow = overflow_q;
    assign bus.o_State          = state_q;

endmodule : cb_cycle_sequencer
